// File: rtl/per_pkg.sv
// Shared definitions for the receive-side send/ack FIFO stage.
package per_pkg;

  localparam int PER_WIDTH = 4;
  localparam int PER_DEPTH = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } rx_state_e;

endpackage

// File: rtl/per_fifo.sv
// Small first-word-fall-through FIFO: the head word is always visible on
// rd_data, and a read just advances the read pointer.
module per_fifo
  import per_pkg::*;
#(
  parameter int DEPTH = PER_DEPTH,
  parameter int WIDTH = PER_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_wr;
  logic             do_rd;

  // Guard both sides so an out-of-range request can never corrupt the count.
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state: pointers and occupancy, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents after reset are don't-care, so no reset here.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);

endmodule

// File: rtl/per_rx_fifo.sv
// Receive stage behind the CPU's send/ack transmitter. One FIFO write per
// four-phase transaction; ack is withheld while the FIFO is full so the
// sender stalls instead of dropping data.
module per_rx_fifo
  import per_pkg::*;
#(
  parameter int DEPTH = PER_DEPTH,
  parameter int WIDTH = PER_WIDTH
) (
  input  logic                   rx_clock,
  input  logic                   rx_reset,
  input  logic                   rx_send,
  input  logic [WIDTH-1:0]       rx_dados_in,
  output logic                   rx_ack,
  output logic                   rx_out_valid,
  input  logic                   rx_out_ready,
  output logic [WIDTH-1:0]       rx_out_dados,
  output logic [$clog2(DEPTH):0] rx_count
);

  rx_state_e state_q, state_d;
  logic      wr_en;
  logic      rd_en;
  logic      fifo_full;
  logic      fifo_empty;

  // Handshake next-state: write only on the IDLE->ACK transition, so a
  // send held high in ACK can never produce a second write.
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_send && !fifo_full) begin
          wr_en   = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!rx_send) state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake state register.
  always_ff @(posedge rx_clock) begin
    if (rx_reset) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Ready while empty is ignored; full is judged on pre-edge occupancy.
  assign rd_en = rx_out_ready && !fifo_empty;

  per_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) u_fifo (
    .clk     (rx_clock),
    .rst     (rx_reset),
    .wr_en   (wr_en),
    .wr_data (rx_dados_in),
    .rd_en   (rd_en),
    .rd_data (rx_out_dados),
    .count   (rx_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign rx_ack       = (state_q == ST_ACK);
  assign rx_out_valid = !fifo_empty;

endmodule

// File: tb/tb_per_rx_fifo.sv
// Scoreboard bench for per_rx_fifo: stimulus pushes expected words, a
// monitor pops and compares on every accepted output word.
module tb_per_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       send;
  logic [3:0] din;
  logic       ack;
  logic       ovalid;
  logic       oready;
  logic [3:0] odata;
  logic [2:0] count;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pops  = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  per_rx_fifo #(.DEPTH(4), .WIDTH(4)) dut (
    .rx_clock     (clk),
    .rx_reset     (rst),
    .rx_send      (send),
    .rx_dados_in  (din),
    .rx_ack       (ack),
    .rx_out_valid (ovalid),
    .rx_out_ready (oready),
    .rx_out_dados (odata),
    .rx_count     (count)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic lvl, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack === lvl) begin
        seen = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: ack got %0d expected %0d within 20 cycles", name, ack, lvl);
    end
  endtask

  // Full four-phase transaction; returns at posedge+1 with send low.
  task automatic send_word(input logic [3:0] d, input int hold);
    exp_q.push_back(d);
    send = 1'b1;
    din  = d;
    wait_ack(1'b1, "ack_rise");
    tick();
    repeat (hold) tick();
    send = 1'b0;
    wait_ack(1'b0, "ack_fall");
    tick();
  endtask

  task automatic pop_one();
    oready = 1'b1;
    tick();
    oready = 1'b0;
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    oready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!ovalid) begin
        done = 1'b1;
        break;
      end
    end
    tick();
    oready = 1'b0;
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s: valid still %0d after 20 cycles, expected 0", name, ovalid);
    end
  endtask

  // Scoreboard monitor: every accepted head word must match the oldest
  // expected word.
  always @(negedge clk) begin
    if (!rst && ovalid && oready) begin
      n_tests++;
      n_pops++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_data: got %0h with nothing expected", odata);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (odata !== e) begin
          n_fail++;
          $display("FAIL pop_data: got %0h expected %0h", odata, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    rst = 1'b1; send = 1'b0; oready = 1'b0; din = 4'h0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_ack", ack, 0);
    chk("rst_valid", ovalid, 0);
    chk("rst_count", count, 0);

    // Single transaction with exact timing.
    exp_q.push_back(4'hA);
    send = 1'b1; din = 4'hA;
    @(negedge clk);
    chk("t1_ack_pre", ack, 0);
    chk("t1_valid_pre", ovalid, 0);
    tick();
    send = 1'b0;
    @(negedge clk);
    chk("t1_ack_hi", ack, 1);
    chk("t1_valid", ovalid, 1);
    chk("t1_dados", odata, 4'hA);
    chk("t1_count", count, 1);
    tick();
    @(negedge clk);
    chk("t1_ack_lo", ack, 0);
    tick();
    pop_one();
    chk("t1_count_after_pop", count, 0);

    // Send held high in ACK for 5 cycles: one write only.
    send_word(4'hB, 5);
    chk("t2_count", count, 1);
    pop_one();
    chk("t2_count_after_pop", count, 0);

    // Fill, then a blocked 5th word.
    send_word(4'h1, 0);
    send_word(4'h2, 0);
    send_word(4'h3, 0);
    send_word(4'h4, 0);
    chk("t3_count_full", count, 4);
    exp_q.push_back(4'h5);
    send = 1'b1; din = 4'h5;
    repeat (3) begin
      @(negedge clk);
      chk("t3_ack_full", ack, 0);
    end
    chk("t3_count_stall", count, 4);
    tick();
    pop_one();
    chk("t3_ack_pop_edge", ack, 0);
    chk("t3_count_pop_edge", count, 3);
    wait_ack(1'b1, "t3_ack_rise");
    tick();
    send = 1'b0;
    wait_ack(1'b0, "t3_ack_fall");
    tick();
    chk("t3_count_refill", count, 4);
    drain("t3_drain");
    chk("t3_count_drained", count, 0);

    // Simultaneous write and pop at count=2.
    send_word(4'h6, 0);
    send_word(4'h7, 0);
    chk("t4_count_pre", count, 2);
    exp_q.push_back(4'h8);
    send = 1'b1; din = 4'h8; oready = 1'b1;
    tick();
    oready = 1'b0;
    chk("t4_count_same", count, 2);
    chk("t4_ack", ack, 1);
    send = 1'b0;
    wait_ack(1'b0, "t4_ack_fall");
    tick();
    drain("t4_drain");

    // Wrap-around stream with ready held high.
    p0 = n_pops;
    oready = 1'b1;
    for (int k = 0; k < 10; k++) send_word(4'(k), 0);
    tick();
    oready = 1'b0;
    chk("t5_pops", n_pops - p0, 10);
    chk("t5_count", count, 0);

    // Reset while in ACK with count=3.
    send_word(4'h1, 0);
    send_word(4'h2, 0);
    send = 1'b1; din = 4'h3;
    wait_ack(1'b1, "t6_ack_rise");
    chk("t6_count_pre", count, 3);
    tick();
    exp_q.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0; send = 1'b0;
    chk("t6_ack", ack, 0);
    chk("t6_valid", ovalid, 0);
    chk("t6_count", count, 0);
    send_word(4'hF, 0);
    chk("t6_count_new", count, 1);
    drain("t6_drain");

    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
